bht_sram_ctrl: RTL and testbench

BHT_SRAM_CTRL -- requirements
Module: bht_sram_ctrl

---
 rtl/bht_pkg.sv | 22 ++
 rtl/bht_sram_ctrl_if.sv | 25 ++
 rtl/bht_sram_ctrl.sv | 135 +++++++++++++
 tb/tb_bht_sram_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared sizing, FSM encoding and counter arithmetic for the branch history table controller.
package bht_pkg;

    localparam int unsigned BHT_DEPTH = 64;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned CTR_W     = 2;

    typedef enum logic {
        StInit,
        StRun
    } bht_state_e;

    // 2-bit saturating counter step: taken moves toward 3, not-taken toward 0.
    function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr,
                                                    input logic             taken);
        if (taken) begin
            return (ctr == '1) ? ctr : ctr + CTR_W'(1);
        end
        return (ctr == '0) ? ctr : ctr - CTR_W'(1);
    endfunction

endpackage

// File: rtl/bht_sram_ctrl_if.sv
// Request/response bundle between branch predictor clients and the BHT SRAM controller.
interface bht_sram_ctrl_if;
    import bht_pkg::*;

    logic             lookup_valid;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_ready;
    logic             resp_valid;
    logic [CTR_W-1:0] resp_counter;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;

    modport master (
        output lookup_valid, lookup_idx, upd_valid, upd_idx, upd_taken,
        input  lookup_ready, resp_valid, resp_counter, upd_ready
    );

    modport slave (
        input  lookup_valid, lookup_idx, upd_valid, upd_idx, upd_taken,
        output lookup_ready, resp_valid, resp_counter, upd_ready
    );

endinterface

// File: rtl/bht_sram_ctrl.sv
// BHT controller: sweeps the external 64x2 SRAM to INIT_VAL after reset, then serves lookups
// and read-modify-write training updates through one shared read port.
module bht_sram_ctrl
    import bht_pkg::*;
#(
    parameter logic [CTR_W-1:0] INIT_VAL = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    bht_sram_ctrl_if.slave   bus,
    output logic             init_done,
    output logic             sram_read_en,
    output logic [IDX_W-1:0] sram_read_addr,
    output logic             sram_write_en,
    output logic [IDX_W-1:0] sram_write_addr,
    output logic [CTR_W-1:0] sram_write_data,
    input  logic [CTR_W-1:0] sram_read_data
);

    bht_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             rr_upd_q, rr_upd_d;
    logic             resp_pend_q, resp_pend_d;
    logic             upd_pend_q, upd_pend_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic             fwd_hit_q, fwd_hit_d;
    logic [CTR_W-1:0] fwd_data_q, fwd_data_d;

    logic             grant_lkp, grant_upd;
    logic             rd_en, wr_en;
    logic [IDX_W-1:0] rd_addr, wr_addr;
    logic [CTR_W-1:0] wr_data, rd_data, new_ctr;

    // A read that collided with a write last cycle takes the written value, not SRAM RDW data.
    always_comb begin
        rd_data = fwd_hit_q ? fwd_data_q : sram_read_data;
        new_ctr = sat_update(rd_data, upd_taken_q);
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        rr_upd_d  = rr_upd_q;
        grant_lkp = 1'b0;
        grant_upd = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        unique case (state_q)
            StInit: begin
                wr_en   = 1'b1;
                wr_addr = sweep_q;
                wr_data = INIT_VAL;
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == IDX_W'(BHT_DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.lookup_valid && bus.upd_valid) begin
                    grant_lkp = !rr_upd_q;
                    grant_upd = rr_upd_q;
                    rr_upd_d  = !rr_upd_q;
                end else begin
                    grant_lkp = bus.lookup_valid;
                    grant_upd = bus.upd_valid;
                end
                rd_en   = grant_lkp || grant_upd;
                rd_addr = grant_upd ? bus.upd_idx : bus.lookup_idx;
                // Second stage of an update accepted last cycle.
                wr_en   = upd_pend_q;
                wr_addr = upd_idx_q;
                wr_data = new_ctr;
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        resp_pend_d = grant_lkp;
        upd_pend_d  = grant_upd;
        upd_idx_d   = grant_upd ? bus.upd_idx : upd_idx_q;
        upd_taken_d = grant_upd ? bus.upd_taken : upd_taken_q;
        fwd_hit_d   = rd_en && wr_en && (rd_addr == wr_addr);
        fwd_data_d  = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            sweep_q     <= '0;
            rr_upd_q    <= 1'b0;
            resp_pend_q <= 1'b0;
            upd_pend_q  <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
            fwd_hit_q   <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            rr_upd_q    <= rr_upd_d;
            resp_pend_q <= resp_pend_d;
            upd_pend_q  <= upd_pend_d;
            upd_idx_q   <= upd_idx_d;
            upd_taken_q <= upd_taken_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign bus.lookup_ready = grant_lkp;
    assign bus.upd_ready    = grant_upd;
    assign bus.resp_valid   = resp_pend_q;
    assign bus.resp_counter = resp_pend_q ? rd_data : '0;
    assign init_done        = (state_q == StRun);
    assign sram_read_en     = rd_en;
    assign sram_read_addr   = rd_addr;

    // The sweep write is decoded from the reset state, so hold it off while rst_n is low.
    always_comb begin
        sram_write_en   = wr_en;
        sram_write_addr = wr_addr;
        sram_write_data = wr_data;
        if (!rst_n) begin
            sram_write_en   = 1'b0;
            sram_write_addr = '0;
            sram_write_data = '0;
        end
    end

endmodule

// File: tb/tb_bht_sram_ctrl.sv
// Bench for bht_sram_ctrl: behavioural 1R1W SRAM, directed vector table, reset sequences and
// a randomized phase checked against a table-level model of the predictor.
module tb_bht_sram_ctrl;
    import bht_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             init_done, sram_read_en, sram_write_en;
    logic [IDX_W-1:0] sram_read_addr, sram_write_addr;
    logic [CTR_W-1:0] sram_write_data, sram_read_data;
    logic [CTR_W-1:0] mem [BHT_DEPTH];

    bht_sram_ctrl_if bus ();

    bht_sram_ctrl #(.INIT_VAL(2'b01)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .init_done       (init_done),
        .sram_read_en    (sram_read_en),
        .sram_read_addr  (sram_read_addr),
        .sram_write_en   (sram_write_en),
        .sram_write_addr (sram_write_addr),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data)
    );

    // Synchronous SRAM: one-cycle read latency, read-during-write returns the old contents.
    always @(posedge clk) begin
        if (sram_read_en) sram_read_data <= mem[sram_read_addr];
        if (sram_write_en) mem[sram_write_addr] <= sram_write_data;
    end

    typedef struct packed {
        logic       lv;
        logic [5:0] lidx;
        logic       uv;
        logic [5:0] uidx;
        logic       tk;
        logic       elr;
        logic       eur;
        logic       erv;
        logic [1:0] erc;
    } vec_t;

    vec_t vecs [27];
    int   n_checks = 0;
    int   n_pass   = 0;

    int         model [BHT_DEPTH];
    bit         l_pend, u_pend, u_tk, rr_upd, g_l, g_u, resp_due, found;
    logic [5:0] l_idx, u_idx;
    int         resp_val;

    function automatic vec_t mk(input bit lv, input int li, input bit uv, input int ui,
                                input bit tk, input bit elr, input bit eur, input bit erv,
                                input int erc);
        vec_t v;
        v.lv = lv;   v.lidx = 6'(li);  v.uv = uv;   v.uidx = 6'(ui); v.tk = tk;
        v.elr = elr; v.eur = eur;      v.erv = erv; v.erc = 2'(erc);
        return v;
    endfunction

    function automatic logic [5:0] rand_idx();
        if ($urandom_range(0, 3) != 0) return 6'($urandom_range(0, 7));
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input bit lv, input logic [5:0] li, input bit uv, input logic [5:0] ui,
                         input bit tk);
        @(negedge clk);
        bus.lookup_valid = lv;
        bus.lookup_idx   = li;
        bus.upd_valid    = uv;
        bus.upd_idx      = ui;
        bus.upd_taken    = tk;
        #2;
    endtask

    task automatic check_zero(input string name);
        check(name, {bus.lookup_ready, bus.upd_ready, bus.resp_valid, bus.resp_counter,
                     init_done, sram_read_en, sram_read_addr, sram_write_en, sram_write_addr,
                     sram_write_data}, 32'h0);
    endtask

    // Called with rst_n low; releases it and checks every cycle of the 64-entry sweep.
    task automatic sweep_check();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < BHT_DEPTH; i++) begin
            bus.lookup_valid = 1'b1;
            bus.upd_valid    = 1'b1;
            #2;
            check($sformatf("sweep[%0d]", i),
                  {init_done, bus.lookup_ready, bus.upd_ready, sram_read_en, sram_write_en,
                   sram_write_addr, sram_write_data},
                  {4'b0000, 1'b1, 6'(i), 2'b01});
            @(negedge clk);
        end
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;
        #2;
        check("init_done_rise", {init_done, bus.lookup_ready, bus.upd_ready}, 3'b100);
    endtask

    initial begin
        vecs[0]  = mk(1, 17, 0, 0,  0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0,  0, 0,  0, 0, 0, 1, 1);
        vecs[2]  = mk(0, 0,  1, 5,  1, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0,  1, 5,  1, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0,  1, 5,  1, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0,  1, 5,  1, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0,  0, 0,  0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 5,  0, 0,  0, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0,  0, 0,  0, 0, 0, 1, 3);
        vecs[9]  = mk(0, 0,  1, 9,  0, 0, 1, 0, 0);
        vecs[10] = mk(1, 9,  0, 0,  0, 1, 0, 0, 0);
        vecs[11] = mk(0, 0,  0, 0,  0, 0, 0, 1, 0);
        vecs[12] = mk(1, 20, 1, 21, 1, 1, 0, 0, 0);
        vecs[13] = mk(1, 20, 1, 21, 1, 0, 1, 1, 1);
        vecs[14] = mk(1, 20, 1, 21, 1, 1, 0, 0, 0);
        vecs[15] = mk(1, 20, 1, 21, 1, 0, 1, 1, 1);
        vecs[16] = mk(1, 20, 1, 21, 1, 1, 0, 0, 0);
        vecs[17] = mk(1, 20, 1, 21, 1, 0, 1, 1, 1);
        vecs[18] = mk(0, 0,  0, 0,  0, 0, 0, 0, 0);
        vecs[19] = mk(1, 21, 0, 0,  0, 1, 0, 0, 0);
        vecs[20] = mk(0, 0,  1, 30, 1, 0, 1, 1, 3);
        vecs[21] = mk(1, 30, 0, 0,  0, 1, 0, 0, 0);
        vecs[22] = mk(1, 63, 0, 0,  0, 1, 0, 1, 2);
        vecs[23] = mk(0, 0,  1, 0,  0, 0, 1, 1, 1);
        vecs[24] = mk(0, 0,  1, 0,  0, 0, 1, 0, 0);
        vecs[25] = mk(1, 0,  0, 0,  0, 1, 0, 0, 0);
        vecs[26] = mk(0, 0,  0, 0,  0, 0, 0, 1, 0);

        // Reset with requests pending: everything must read as zero.
        rst_n = 1'b0;
        bus.lookup_valid = 1'b1;
        bus.lookup_idx   = 6'd17;
        bus.upd_valid    = 1'b1;
        bus.upd_idx      = 6'd3;
        bus.upd_taken    = 1'b1;
        #1;
        check_zero("reset_async");
        repeat (3) @(negedge clk);
        #2;
        check_zero("reset_held");

        sweep_check();

        foreach (vecs[i]) begin
            drive(vecs[i].lv, vecs[i].lidx, vecs[i].uv, vecs[i].uidx, vecs[i].tk);
            check($sformatf("vec[%0d].ready", i), {bus.lookup_ready, bus.upd_ready},
                  {vecs[i].elr, vecs[i].eur});
            check($sformatf("vec[%0d].resp", i), {bus.resp_valid, bus.resp_counter},
                  {vecs[i].erv, vecs[i].erc});
        end

        // Reset while running restarts the sweep from entry 0.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_run");
        sweep_check();

        // Randomized traffic against a table model applied in acceptance order.
        for (int i = 0; i < BHT_DEPTH; i++) model[i] = 1;
        l_pend = 0; u_pend = 0; rr_upd = 0; resp_due = 0; resp_val = 0;
        l_idx = '0; u_idx = '0; u_tk = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!l_pend && $urandom_range(0, 2) != 0) begin
                l_pend = 1;
                l_idx  = rand_idx();
            end
            if (!u_pend && $urandom_range(0, 2) != 0) begin
                u_pend = 1;
                u_idx  = rand_idx();
                u_tk   = 1'($urandom_range(0, 1));
            end
            drive(l_pend, l_idx, u_pend, u_idx, u_tk);
            g_l = l_pend && !(u_pend && rr_upd);
            g_u = u_pend && !(l_pend && !rr_upd);
            if (l_pend && u_pend) rr_upd = !rr_upd;
            check($sformatf("rand[%0d].ready", c), {bus.lookup_ready, bus.upd_ready}, {g_l, g_u});
            check($sformatf("rand[%0d].resp", c), {bus.resp_valid, bus.resp_counter},
                  {resp_due, 2'(resp_val)});
            resp_due = 0;
            resp_val = 0;
            if (g_l) begin
                resp_due = 1;
                resp_val = model[l_idx];
                l_pend   = 0;
            end
            if (g_u) begin
                if (u_tk) model[u_idx] = (model[u_idx] == 3) ? 3 : model[u_idx] + 1;
                else      model[u_idx] = (model[u_idx] == 0) ? 0 : model[u_idx] - 1;
                u_pend = 0;
            end
        end

        // Reset landing mid-sweep at entry 30.
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        found = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            #2;
            if (sram_write_en && sram_write_addr == 6'd30) found = 1;
            else @(negedge clk);
        end
        check("reach_sweep_30", {31'b0, found}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_init");
        sweep_check();

        drive(1, 6'd5, 0, 0, 0);
        check("post_reinit.ready", bus.lookup_ready, 1'b1);
        drive(0, 0, 0, 0, 0);
        check("post_reinit.resp", {bus.resp_valid, bus.resp_counter}, 3'b101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
